// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory (slave).
// One request may be outstanding; rdata is qualified by rvalid.
interface fetch_stage_if;
    logic        req;
    logic [15:0] adr;
    logic        ack;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (output req, adr, input ack, rvalid, rdata);
    modport slave  (input req, adr, output ack, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests, buffers
// returned words and loads the IF/ID register consumed by decode.
//
// state   | meaning
// IDLE    | no outstanding request; may issue when enabled and buffer has room
// WAIT    | request acked, returning word will be buffered
// DISCARD | request acked before a redirect, returning word will be dropped
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INST   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_pc,
    input  logic          en_ifid,
    input  logic          flush_ifid,
    input  logic          redirect,
    input  logic [15:0]   redirect_adr,
    fetch_stage_if.master imem,
    output logic [15:0]   inst_id,
    output logic [15:0]   pcinc_id,
    output logic          valid_id
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t           state, state_nxt;
    logic [15:0]      pc;
    logic [15:0]      buf_inst  [FIFO_DEPTH];
    logic [15:0]      buf_pcinc [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             buf_empty, issue, push, pop;

    // Gating with reset keeps req low while reset is held, whatever en_pc does.
    assign imem.req  = reset & (state == IDLE) & en_pc & ~redirect & (count < DEPTH_CNT);
    assign imem.adr  = pc;
    assign buf_empty = (count == '0);
    assign issue     = imem.req & imem.ack;
    assign push      = (state == WAIT) & imem.rvalid & ~redirect;
    assign pop       = ~flush_ifid & en_ifid & ~buf_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT: begin
                if (imem.rvalid)   state_nxt = IDLE;
                else if (redirect) state_nxt = DISCARD;
            end
            DISCARD: if (imem.rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)   pc <= redirect_adr;
            else if (issue) pc <= pc + 16'd1;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push & ~pop)      count <= count + (PTR_W + 1)'(1);
                else if (pop & ~push) count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // In WAIT the PC has already advanced past the issued address, so it is the pcinc.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr]  <= imem.rdata;
            buf_pcinc[wr_ptr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_id  <= NOP_INST;
            pcinc_id <= 16'h0000;
            valid_id <= 1'b0;
        end else if (flush_ifid) begin
            inst_id  <= NOP_INST;
            valid_id <= 1'b0;
        end else if (en_ifid) begin
            if (!buf_empty) begin
                inst_id  <= buf_inst[rd_ptr];
                pcinc_id <= buf_pcinc[rd_ptr];
                valid_id <= 1'b1;
            end else begin
                inst_id  <= NOP_INST;
                valid_id <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table for steady fetch and decode stall, then
// directed sequences for redirects, flush, PC wrap and mid-transaction reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        en_pc, en_ifid, flush_ifid, redirect;
    logic [15:0] redirect_adr;
    logic [15:0] inst_id, pcinc_id;
    logic        valid_id;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk(clk), .reset(reset), .en_pc(en_pc), .en_ifid(en_ifid),
        .flush_ifid(flush_ifid), .redirect(redirect), .redirect_adr(redirect_adr),
        .imem(imem.master), .inst_id(inst_id), .pcinc_id(pcinc_id), .valid_id(valid_id)
    );

    always #5 clk = ~clk;

    // Memory model: acks immediately, returns data lat cycles after the ack.
    int          lat = 1;
    logic        busy;
    int          wait_cnt;
    logic [15:0] rv_adr;

    function automatic logic [15:0] inst_of(input logic [15:0] a);
        return a ^ 16'hB000;
    endfunction

    assign imem.ack    = imem.req;
    assign imem.rvalid = busy && (wait_cnt == 0);
    assign imem.rdata  = imem.rvalid ? inst_of(rv_adr) : 16'hDEAD;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            wait_cnt <= 0;
            rv_adr   <= 16'h0;
        end else begin
            if (busy) begin
                if (wait_cnt == 0) busy <= 1'b0;
                else               wait_cnt <= wait_cnt - 1;
            end
            if (imem.req && imem.ack) begin
                busy     <= 1'b1;
                wait_cnt <= lat - 1;
                rv_adr   <= imem.adr;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en_pc = 1'b1; en_ifid = 1'b1; flush_ifid = 1'b0;
        redirect = 1'b0; redirect_adr = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name, input logic [15:0] exp_inst,
                              input logic [15:0] exp_pcinc);
        for (int k = 0; k < 20; k++) begin
            if (valid_id) break;
            @(negedge clk); #1;
        end
        check({name, "_valid"}, 16'(valid_id), 16'h1);
        check({name, "_inst"},  inst_id,  exp_inst);
        check({name, "_pcinc"}, pcinc_id, exp_pcinc);
    endtask

    typedef struct {
        logic        en_ifid;
        logic        req;
        logic [15:0] adr;
        logic [15:0] inst;
        logic [15:0] pcinc;
        logic        valid;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic r, input logic [15:0] a,
                                input logic [15:0] i, input logic [15:0] p, input logic v);
        vec_t x;
        x.en_ifid = e; x.req = r; x.adr = a; x.inst = i; x.pcinc = p; x.valid = v;
        return x;
    endfunction

    vec_t vecs [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // cycle: en_ifid, req, adr, inst_id, pcinc_id, valid_id (outputs from previous edges)
        vecs[0]  = mk(1, 1, 16'h0000, 16'h0000, 16'h0000, 0);
        vecs[1]  = mk(1, 0, 16'h0001, 16'h0000, 16'h0000, 0);
        vecs[2]  = mk(1, 1, 16'h0001, 16'h0000, 16'h0000, 0);
        vecs[3]  = mk(1, 0, 16'h0002, 16'hB000, 16'h0001, 1);
        vecs[4]  = mk(1, 1, 16'h0002, 16'h0000, 16'h0001, 0);
        vecs[5]  = mk(1, 0, 16'h0003, 16'hB001, 16'h0002, 1);
        vecs[6]  = mk(1, 1, 16'h0003, 16'h0000, 16'h0002, 0);
        vecs[7]  = mk(0, 0, 16'h0004, 16'hB002, 16'h0003, 1);
        vecs[8]  = mk(0, 1, 16'h0004, 16'hB002, 16'h0003, 1);
        vecs[9]  = mk(0, 0, 16'h0005, 16'hB002, 16'h0003, 1);
        vecs[10] = mk(0, 0, 16'h0005, 16'hB002, 16'h0003, 1);
        vecs[11] = mk(0, 0, 16'h0005, 16'hB002, 16'h0003, 1);
        vecs[12] = mk(0, 0, 16'h0005, 16'hB002, 16'h0003, 1);
        vecs[13] = mk(1, 0, 16'h0005, 16'hB002, 16'h0003, 1);
        vecs[14] = mk(1, 1, 16'h0005, 16'hB003, 16'h0004, 1);
        vecs[15] = mk(1, 0, 16'h0006, 16'hB004, 16'h0005, 1);
        vecs[16] = mk(1, 1, 16'h0006, 16'h0000, 16'h0005, 0);
        vecs[17] = mk(1, 0, 16'h0007, 16'hB005, 16'h0006, 1);

        // Reset values, with req forced low while reset is held
        reset = 1'b0;
        en_pc = 1'b1; en_ifid = 1'b1; flush_ifid = 1'b0;
        redirect = 1'b0; redirect_adr = 16'h0;
        @(negedge clk); #1;
        check("rst_req",   16'(imem.req), 16'h0);
        check("rst_adr",   imem.adr, 16'h0000);
        check("rst_inst",  inst_id,  16'h0000);
        check("rst_pcinc", pcinc_id, 16'h0000);
        check("rst_valid", 16'(valid_id), 16'h0);

        // Steady fetch, then decode stall and release
        lat = 1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i != 0) @(negedge clk);
            en_ifid = vecs[i].en_ifid;
            #1;
            check($sformatf("v%0d_req", i),   16'(imem.req), 16'(vecs[i].req));
            check($sformatf("v%0d_adr", i),   imem.adr, vecs[i].adr);
            check($sformatf("v%0d_inst", i),  inst_id,  vecs[i].inst);
            check($sformatf("v%0d_pcinc", i), pcinc_id, vecs[i].pcinc);
            check($sformatf("v%0d_valid", i), 16'(valid_id), 16'(vecs[i].valid));
        end

        // Redirect in WAIT, stale word returns three cycles later and must be dropped
        lat = 4;
        do_reset();
        #1;
        check("rdw_req0", 16'(imem.req), 16'h1);
        @(negedge clk);
        redirect = 1'b1; redirect_adr = 16'h0040;
        #1;
        check("rdw_req1", 16'(imem.req), 16'h0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            check($sformatf("rdw_c%0d_req", c), 16'(imem.req), 16'h0);
            check($sformatf("rdw_c%0d_adr", c), imem.adr, 16'h0040);
        end
        @(negedge clk); #1;
        check("rdw_req5", 16'(imem.req), 16'h1);
        check("rdw_adr5", imem.adr, 16'h0040);
        wait_valid("rdw_first", 16'hB040, 16'h0041);

        // Redirect coinciding with rvalid in WAIT
        lat = 1;
        do_reset();
        @(negedge clk);
        redirect = 1'b1; redirect_adr = 16'h1234;
        #1;
        check("rdr_rvalid", 16'(imem.rvalid), 16'h1);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("rdr_req",   16'(imem.req), 16'h1);
        check("rdr_adr",   imem.adr, 16'h1234);
        check("rdr_valid", 16'(valid_id), 16'h0);
        wait_valid("rdr_first", 16'hA234, 16'h1235);

        // en_pc blocks issue; flush with a non-empty buffer
        do_reset();
        en_pc = 1'b0; en_ifid = 1'b0;
        #1;
        check("enpc_req", 16'(imem.req), 16'h0);
        @(negedge clk);
        en_pc = 1'b1;
        #1;
        check("enpc_req1", 16'(imem.req), 16'h1);
        check("enpc_adr1", imem.adr, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        flush_ifid = 1'b1; en_ifid = 1'b1;
        @(negedge clk);
        flush_ifid = 1'b0;
        #1;
        check("fl_inst",  inst_id, 16'h0000);
        check("fl_valid", 16'(valid_id), 16'h0);
        check("fl_pcinc", pcinc_id, 16'h0000);
        @(negedge clk); #1;
        check("fl_next_inst",  inst_id, 16'hB000);
        check("fl_next_pcinc", pcinc_id, 16'h0001);
        check("fl_next_valid", 16'(valid_id), 16'h1);

        // PC wrap at 16'hFFFF, then reset during WAIT
        do_reset();
        redirect = 1'b1; redirect_adr = 16'hFFFF;
        #1;
        check("wr_req_withdrawn", 16'(imem.req), 16'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("wr_req", 16'(imem.req), 16'h1);
        check("wr_adr", imem.adr, 16'hFFFF);
        @(negedge clk);
        @(negedge clk); #1;
        check("wr_next_adr", imem.adr, 16'h0000);
        check("wr_next_req", 16'(imem.req), 16'h1);
        @(negedge clk); #1;
        check("wr_inst",  inst_id,  16'h4FFF);
        check("wr_pcinc", pcinc_id, 16'h0000);
        check("wr_valid", 16'(valid_id), 16'h1);
        #1 reset = 1'b0;
        #1;
        check("mr_inst",  inst_id,  16'h0000);
        check("mr_pcinc", pcinc_id, 16'h0000);
        check("mr_valid", 16'(valid_id), 16'h0);
        check("mr_req",   16'(imem.req), 16'h0);
        check("mr_adr",   imem.adr, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_restart_req", 16'(imem.req), 16'h1);
        check("mr_restart_adr", imem.adr, 16'h0000);
        wait_valid("mr_first", 16'hB000, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
